// File: rtl/rs232_rx_if.sv
// Output bundle of the distance-link receiver.
// master: rs232_rx drives it; slave: the consumer.
interface rs232_rx_if;
  logic [11:0] data_out;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err
  );

  modport slave (
    input data_out,
    input data_valid,
    input parity_err,
    input frame_err
  );
endinterface

// File: rtl/rs232_rx.sv
// Two-frame 12-bit distance receiver for an 11-bit serial frame.
// Ports: clk, n_rst (async low), rx (serial in), bus (rs232_rx_if.master).
module rs232_rx #(
  parameter int BIT_CYCLES = 5209
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx,
  rs232_rx_if.master  bus
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] LAST =
    CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rxs;
  logic        rxs_prev;
  logic [1:0]  warm;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  d;
  logic        par;
  logic [6:0]  low_reg;
  logic        low_ok;
  logic [11:0] data_q;
  logic        valid_q;
  logic        perr_q;
  logic        ferr_q;

  logic fall;
  logic hit;
  logic par_ok;

  // Edges are ignored until the synchronizer has
  // flushed its reset value, so a line held low
  // across reset release is not taken as a start.
  assign fall   = rxs_prev & ~rxs & (warm == 2'd3);
  assign hit    = (cnt == LAST);
  assign par_ok = ((^d[7:1]) == par);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      warm     <= 2'd0;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= 3'd0;
      d        <= 8'h00;
      par      <= 1'b0;
      low_reg  <= 7'h00;
      low_ok   <= 1'b0;
      data_q   <= 12'h000;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      if (warm != 2'd3)
        warm <= warm + 2'd1;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (fall)
            state <= START;
        end
        START: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              idx   <= 3'd0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (hit) begin
            cnt    <= '0;
            d[idx] <= rxs;
            idx    <= idx + 3'd1;
            if (idx == 3'd7)
              state <= PARITY;
          end
        end
        PARITY: begin
          cnt <= cnt + 1'b1;
          if (hit) begin
            cnt   <= '0;
            par   <= rxs;
            state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          if (hit) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rxs) begin
              ferr_q <= 1'b1;
              low_ok <= 1'b0;
            end else if (!par_ok) begin
              perr_q <= 1'b1;
              low_ok <= 1'b0;
            end else if (!d[0]) begin
              low_reg <= d[7:1];
              low_ok  <= 1'b1;
            end else if (low_ok) begin
              data_q  <= {d[5:1], low_reg};
              valid_q <= 1'b1;
              low_ok  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule
